// File: rtl/tpu_pkg.sv
// Shared definitions for the tpumac systolic array and its feeders.
// Holds the default operand width and array dimension plus the
// operand/row typedefs used across the MAC datapath.
package tpu_pkg;

    localparam int unsigned BITS_AB_DEF = 8;
    localparam int unsigned DIM_DEF     = 8;

    typedef logic signed [BITS_AB_DEF-1:0] a_t;
    typedef a_t [DIM_DEF-1:0]              a_row_t;

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated delay line of DEPTH register stages, reset to zero.
// DEPTH = 0 degenerates to a straight wire from d to q.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned BITS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        // Clock, reset and enable have no role in a zero-depth lane.
        logic unused;
        assign unused = &{1'b0, clk, rst_n, en};
        assign q = d;
    end else begin : g_regs
        logic [BITS-1:0] stage [DEPTH];

        // Shift one stage per enabled cycle; stage 0 takes the new sample.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else if (en) begin
                stage[0] <= d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/mac_row_skewer.sv
// Input-side feeder for the tpumac systolic array. Holds a DIM x DIM tile
// of A operands and emits one column per enabled cycle, row r delayed by
// r cycles so the diagonal wavefront meets each MAC row on time.
// Optional feature: define MAC_ROW_SKEWER_DONE_EN to add the drain counter
// driving 'done'; otherwise 'done' is tied low.
module mac_row_skewer
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_AB = BITS_AB_DEF,
    parameter int unsigned DIM     = DIM_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           WrEn,
    input  logic [$clog2(DIM)-1:0]         Arow,
    input  logic signed [DIM*BITS_AB-1:0]  Ain,
    output logic signed [DIM*BITS_AB-1:0]  Aout,
    output logic                           done
);

    localparam int unsigned AW = $clog2(DIM);

    logic [BITS_AB-1:0] rowbuf [DIM][DIM];
    logic [BITS_AB-1:0] lane_q [DIM];
    logic [DIM-1:0]     wr_sel;

    // One-hot row select; an out-of-range Arow selects nothing.
    always_comb begin
        wr_sel = '0;
        for (int unsigned r = 0; r < DIM; r++) begin
            wr_sel[r] = WrEn && (Arow == AW'(r));
        end
    end

    // Row buffers: the written row loads (and does not shift), every other
    // row shifts toward its head on en, back-filling zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DIM; r++) begin
                for (int unsigned c = 0; c < DIM; c++) begin
                    rowbuf[r][c] <= '0;
                end
            end
        end else begin
            for (int unsigned r = 0; r < DIM; r++) begin
                if (wr_sel[r]) begin
                    for (int unsigned c = 0; c < DIM; c++) begin
                        rowbuf[r][c] <= Ain[c*BITS_AB +: BITS_AB];
                    end
                end else if (en) begin
                    for (int unsigned c = 0; c < DIM - 1; c++) begin
                        rowbuf[r][c] <= rowbuf[r][c+1];
                    end
                    rowbuf[r][DIM-1] <= '0;
                end
            end
        end
    end

    // Lane r delays its row head by r enabled cycles. Every lane shifts on
    // en, including a lane whose row is being written in the same cycle, so
    // it captures the pre-write head.
    for (genvar r = 0; r < DIM; r++) begin : g_lane
        skew_delay_line #(
            .DEPTH (r),
            .BITS  (BITS_AB)
        ) u_dl (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .d     (rowbuf[r][0]),
            .q     (lane_q[r])
        );

        assign Aout[r*BITS_AB +: BITS_AB] = lane_q[r];
    end

`ifdef MAC_ROW_SKEWER_DONE_EN
    localparam int unsigned    CW      = $clog2(2 * DIM);
    localparam logic [CW-1:0]  CNT_MAX = CW'(2 * DIM - 1);

    logic [CW-1:0] drain_cnt;

    // Count enabled cycles since the last write, saturating once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (WrEn) begin
            drain_cnt <= '0;
        end else if (en && (drain_cnt != CNT_MAX)) begin
            drain_cnt <= drain_cnt + CW'(1);
        end
    end

    assign done = (drain_cnt == CNT_MAX);
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_mac_row_skewer.sv
// Self-checking bench for mac_row_skewer at DIM=4, BITS_AB=8 with
// A[r][c] = 16*r + c + 1. Expectations go to a scoreboard queue as each
// vector is driven and are popped after the following clock edge.
module tb_mac_row_skewer;

    localparam int unsigned DIM  = 4;
    localparam int unsigned BITS = 8;
    localparam int unsigned W    = DIM * BITS;

`ifdef MAC_ROW_SKEWER_DONE_EN
    localparam bit DONE_EN = 1'b1;
`else
    localparam bit DONE_EN = 1'b0;
`endif

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                en    = 1'b0;
    logic                WrEn  = 1'b0;
    logic [1:0]          Arow  = '0;
    logic signed [W-1:0] Ain   = '0;
    logic signed [W-1:0] Aout;
    logic                done;

    always #5 clk = ~clk;

    mac_row_skewer #(
        .BITS_AB (BITS),
        .DIM     (DIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .WrEn  (WrEn),
        .Arow  (Arow),
        .Ain   (Ain),
        .Aout  (Aout),
        .done  (done)
    );

    typedef struct {
        logic [63:0] tag;
        logic        en;
        logic        wr;
        logic [1:0]  row;
        logic [31:0] ain;
        logic [31:0] exp_aout;
        logic        exp_done;
    } vec_t;

    typedef struct {
        logic [63:0] tag;
        logic [31:0] aout;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    logic [31:0] rows [4];
    logic [31:0] kexp [8];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    function automatic logic [31:0] pk(int a0, int a1, int a2, int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic vec_t mk(logic [63:0] tag, logic e, logic w, logic [1:0] r,
                                logic [31:0] ain, logic [31:0] ea, logic ed);
        vec_t v;
        v.tag = tag; v.en = e; v.wr = w; v.row = r;
        v.ain = ain; v.exp_aout = ea; v.exp_done = ed;
        return v;
    endfunction

    task automatic expect_now(logic [63:0] tag, logic [31:0] a, logic d);
        exp_t e;
        e.tag  = tag;
        e.aout = a;
        e.done = d & DONE_EN;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: empty queue at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if (Aout !== e.aout || done !== e.done) begin
                n_bad++;
                $display("FAIL %s: Aout=%h done=%b, expected Aout=%h done=%b (t=%0t)",
                         e.tag, Aout, done, e.aout, e.done, $time);
            end
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        en   = v.en;
        WrEn = v.wr;
        Arow = v.row;
        Ain  = v.ain;
        expect_now(v.tag, v.exp_aout, v.exp_done);
        @(posedge clk);
        #1;
        check();
        en   = 1'b0;
        WrEn = 1'b0;
    endtask

    task automatic load_tile();
        for (int r = 0; r < 4; r++) begin
            apply(mk("load", 1'b0, 1'b1, 2'(r), rows[r], pk(1, 0, 0, 0), 1'b0));
        end
    endtask

    // Drop reset mid-cycle and check outputs before any clock edge.
    task automatic rst_pulse(logic [63:0] tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_now(tag, '0, 1'b0);
        check();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rows[0] = 32'h04030201;
        rows[1] = 32'h14131211;
        rows[2] = 32'h24232221;
        rows[3] = 32'h34333231;

        kexp[0] = pk(1,  0,  0,  0);
        kexp[1] = pk(2, 17,  0,  0);
        kexp[2] = pk(3, 18, 33,  0);
        kexp[3] = pk(4, 19, 34, 49);
        kexp[4] = pk(0, 20, 35, 50);
        kexp[5] = pk(0,  0, 36, 51);
        kexp[6] = pk(0,  0,  0, 52);
        kexp[7] = pk(0,  0,  0,  0);

        for (int k = 1; k < 8; k++) begin
            tbl.push_back(mk("drain", 1'b1, 1'b0, 2'd0, '0, kexp[k], (k == 7)));
        end
        tbl.push_back(mk("sat",  1'b1, 1'b0, 2'd0, '0, '0, 1'b1));
        tbl.push_back(mk("idle", 1'b0, 1'b0, 2'd0, '0, '0, 1'b1));

        // Reset state, checked while reset is still asserted.
        #2;
        expect_now("rst_init", '0, 1'b0);
        check();
        @(negedge clk);
        rst_n = 1'b1;

        // Skew drain through the full 2*DIM-1 window, then saturation.
        load_tile();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Stall: outputs freeze while en is low, then resume unchanged.
        load_tile();
        apply(mk("stall_en", 1'b1, 1'b0, 2'd0, '0, kexp[1], 1'b0));
        for (int i = 0; i < 3; i++) begin
            apply(mk("stall", 1'b0, 1'b0, 2'd0, '0, kexp[1], 1'b0));
        end
        for (int k = 2; k < 8; k++) begin
            apply(mk("resume", 1'b1, 1'b0, 2'd0, '0, kexp[k], (k == 7)));
        end

        // Negative values pass through bit-exact on lane 0.
        apply(mk("neg_wr", 1'b0, 1'b1, 2'd0, 32'h007FFF80, 32'h00000080, 1'b0));
        apply(mk("neg_k1", 1'b1, 1'b0, 2'd0, '0, 32'h000000FF, 1'b0));
        apply(mk("neg_k2", 1'b1, 1'b0, 2'd0, '0, 32'h0000007F, 1'b0));
        apply(mk("neg_k3", 1'b1, 1'b0, 2'd0, '0, 32'h00000000, 1'b0));

        // Simultaneous write of row 1 and shift at k=2.
        load_tile();
        apply(mk("sim_k1", 1'b1, 1'b0, 2'd0, '0, kexp[1], 1'b0));
        apply(mk("sim_k2", 1'b1, 1'b0, 2'd0, '0, kexp[2], 1'b0));
        apply(mk("simul", 1'b1, 1'b1, 2'd1, 32'h09090909, pk(4, 19, 34, 49), 1'b0));
        apply(mk("sim_p1", 1'b1, 1'b0, 2'd0, '0, pk(0, 9, 35, 50), 1'b0));
        apply(mk("sim_p2", 1'b1, 1'b0, 2'd0, '0, pk(0, 9, 36, 51), 1'b0));

        // Reset from a live state, then reset mid-drain at k=3.
        rst_pulse("rst_live");
        load_tile();
        for (int k = 1; k < 4; k++) begin
            apply(mk("pre_rst", 1'b1, 1'b0, 2'd0, '0, kexp[k], 1'b0));
        end
        rst_pulse("rst_mid");
        apply(mk("post_rst", 1'b1, 1'b0, 2'd0, '0, '0, 1'b0));

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_row_skewer.md
# mac_row_skewer

Input-side feeder for the systolic array of `tpumac` cells. It holds a DIM×DIM tile of A operands and emits one column per enabled cycle, with row r delayed by r cycles. The diagonal wavefront reaches the `Ain` of the leftmost MAC in each array row exactly when that row needs it. It sits directly upstream of the MAC array's A inputs and is loaded row-by-row by the host/memory interface.

## Interface
Parameters:
- `BITS_AB`, default 8: operand width, matching the MAC's `BITS_AB`.
- `DIM`, default 8: array dimension (rows and columns); must be ≥ 2.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `en`  in  1: advance one column (shift the row buffers and the skew delay lines).
- `WrEn`  in  1: load one full row from `Ain` into row `Arow`.
- `Arow`  in  $clog2(DIM): row index for `WrEn`.
- `Ain`  in  DIM×BITS_AB (signed, packed): row data; element c occupies bits [c*BITS_AB +: BITS_AB].
- `Aout`  out  DIM×BITS_AB (signed, packed): skewed column; lane r drives MAC row r.
- `done`  out  1: tile fully drained (see Configuration).

## Operation
State:
- Row buffer `buf[r][0..DIM-1]`. Element 0 is the head.
- Per-lane skew delay line of depth r, implemented as registers. Lane 0 has depth 0.
- Drain counter (optional).

Write:
- `WrEn`=1 sets `buf[Arow][c] <= Ain[c]` for all c.
- Other rows are unaffected by the write.

Shift:
- `en`=1 shifts every row: `buf[r][c] <= buf[r][c+1]`, `buf[r][DIM-1] <= 0`.
- `buf[r][0]` enters lane r's delay line, and the delay line shifts one stage.

Output:
- `Aout[r]` is the last stage of lane r's delay line.
- For r=0, `Aout[0]` is combinationally `buf[0][0]`.
- Let k be the number of `en` cycles since a full tile load, with the delay lines holding zeros. Then `Aout[r] = A[r][k−r]` if 0 ≤ k−r < DIM, else 0.
- The last nonzero element appears at k = 2·DIM−2. At k = 2·DIM−1, all lanes read 0.

Simultaneous `WrEn` and `en`:
- Row `Arow` takes the new `Ain` and does not shift.
- All other rows shift.
- All delay lines shift; lane `Arow`'s delay line takes the pre-write `buf[Arow][0]`.

Idle and arithmetic:
- With `en`=0 and `WrEn`=0, all state holds.
- No arithmetic is performed; values pass through bit-exact, sign preserved.

## Timing
- Reset (async assert, sync deassert at the source): all `buf`, delay registers, and the counter go to 0. `Aout` = 0. `done` = 0.
- Write latency: 1 cycle. `Aout[0]` reflects a row-0 write at the next edge; other lanes only after `en`.
- Lane r latency from the row buffer head to `Aout[r]`: r `en` cycles. It is not a clock-cycle count, because cycles with `en`=0 stall all lanes uniformly.
- Full tile drain: 2·DIM−1 `en` cycles after the last `WrEn`.
- Reset mid-drain: all state clears immediately, and `Aout` = 0 asynchronously.
- `Arow` ≥ DIM is not possible for power-of-two DIM. For other DIM, an out-of-range write is ignored.

## Configuration
- Macro: `MAC_ROW_SKEWER_DONE_EN`.
- **Defined:**
  - Adds a $clog2(2·DIM) counter, cleared to 0 by any `WrEn`.
  - The counter increments on each `en` cycle without `WrEn`, saturating at 2·DIM−1.
  - `done` = 1 while the counter equals 2·DIM−1.
- **Undefined:** no counter, and `done` is tied to 0.

## Structure
- Shared package `tpu_pkg`:
  - Default `BITS_AB` and `DIM` localparams, shared with the MAC and array.
  - Typedef for a signed operand `a_t`.
  - Typedef for a packed row `a_row_t` (DIM × `a_t`).
- Sub-module `skew_delay_line`:
  - Parameters: `DEPTH`, `BITS`.
  - Ports: `clk`, `rst_n`, `en`, `d`, `q`.
  - `DEPTH`=0 is a wire.
  - Instantiated once per lane through a generate loop.

## Test plan
All cases use DIM=4 and BITS_AB=8, with A[r][c] = 16·r + c + 1.
- **Reset:** assert `rst_n`=0 mid-cycle → `Aout`=0 and `done`=0 immediately, without waiting for a clock edge.
- **Skew drain:** load rows 0–3, then apply 7 `en` cycles. After k=0..6, `Aout` lanes (0,1,2,3) read (1,0,0,0), (2,17,0,0), (3,18,33,0), (4,19,34,49), (0,20,35,50), (0,0,36,51), (0,0,0,52). `done`=1 after the 7th `en` (macro defined).
- **Stall:** same load; apply `en` on k=0,1, then `en`=0 for 3 cycles → `Aout` holds (2,17,0,0) for all 3 stalled cycles, and the sequence then resumes identically.
- **Negative values:** row 0 = {−128, −1, 127, 0} → `Aout[0]` sequence over 4 `en` cycles is exactly 0x80, 0xFF, 0x7F, 0x00.
- **Simultaneous write/shift:** with a tile loaded and k=2, assert `WrEn` (Arow=1, Ain={9,9,9,9}) together with `en` → row 1's buffer becomes {9,9,9,9}, the other rows shift, and `done` is cleared.
- **Reset mid-drain:** at k=3, pulse `rst_n` low → all lanes read 0, and a subsequent `en` keeps them at 0.
